booth_pp_gen: RTL and testbench

BOOTH_PP_GEN -- requirements
Module: booth_pp_gen

---
 rtl/booth_pp_gen.sv | 102 ++++++++++
 tb/tb_booth_pp_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator with a two-stage valid/ready pipeline.
// Stage S1 captures the multiplicand and the Booth digit selects.
// Stage S2 holds the partial products and the +1 negation corrections.
// Both stages share one enable, so a stalled output freezes the whole pipeline.
module booth_pp_gen #(
  parameter int MBITS = 12,
  parameter int NBITS = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [MBITS-1:0]                       a_in,
  input  logic [NBITS-1:0]                       b_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [(NBITS/2)*(MBITS+1)-1:0]         pp_bus,
  output logic [(NBITS/2)-1:0]                   neg,
  output logic                                   busy
);

  localparam int NPP = NBITS / 2;
  localparam int PPW = MBITS + 1;

  logic                 en;
  logic                 s1_valid_reg;
  logic [MBITS-1:0]     s1_a_reg;
  logic [NPP-1:0]       s1_one_reg;
  logic [NPP-1:0]       s1_two_reg;
  logic [NPP-1:0]       s1_negsel_reg;
  logic [NPP-1:0]       one_next;
  logic [NPP-1:0]       two_next;
  logic [NPP-1:0]       negsel_next;
  logic [NBITS:0]       b_ext;
  logic [PPW-1:0]       a_ext;
  logic [NPP*PPW-1:0]   pp_next;

  // The pipeline moves only when the output slot is empty or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign busy     = s1_valid_reg || out_valid;

  // Implicit b[-1] = 0 appended below the LSB so every digit sees a full triplet.
  assign b_ext = {b_in, 1'b0};
  assign a_ext = {s1_a_reg[MBITS-1], s1_a_reg};

  generate
    for (genvar gi = 0; gi < NPP; gi++) begin : g_digit
      logic [2:0]     trip;
      logic [PPW-1:0] mag;

      // Digit recode: one -> |d|=1, two -> |d|=2, negsel -> d<0 (111 is a plain zero).
      assign trip            = b_ext[2*gi+2 : 2*gi];
      assign one_next[gi]    = trip[1] ^ trip[0];
      assign two_next[gi]    = (trip == 3'b011) || (trip == 3'b100);
      assign negsel_next[gi] = trip[2] & ~(trip[1] & trip[0]);

      // |d|*A in MBITS+1 bits; 2A always fits, including A = -2^(MBITS-1).
      assign mag = s1_one_reg[gi] ? a_ext :
                   (s1_two_reg[gi] ? {s1_a_reg, 1'b0} : '0);

      // Negative digits emit the one's complement; the missing +1 travels on neg.
      assign pp_next[gi*PPW +: PPW] = s1_negsel_reg[gi] ? ~mag : mag;
    end
  endgenerate

  // Stage S1: capture operand A and the recoded Booth selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_one_reg    <= '0;
      s1_two_reg    <= '0;
      s1_negsel_reg <= '0;
    end else if (en) begin
      s1_valid_reg  <= in_valid;
      s1_a_reg      <= a_in;
      s1_one_reg    <= one_next;
      s1_two_reg    <= two_next;
      s1_negsel_reg <= negsel_next;
    end
  end

  // Stage S2: register the partial-product set presented to the CSA tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pp_bus    <= '0;
      neg       <= '0;
    end else if (en) begin
      out_valid <= s1_valid_reg;
      pp_bus    <= pp_next;
      neg       <= negsel_next_q();
    end
  end

  // The S2 neg bits are simply the registered negative-digit selects from S1.
  function automatic logic [NPP-1:0] negsel_next_q();
    return s1_negsel_reg;
  endfunction

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen at default widths (MBITS=12, NBITS=8).
module tb_booth_pp_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [51:0] pp_bus;
  logic [3:0]  neg;
  logic        busy;

  booth_pp_gen #(.MBITS(12), .NBITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_bus    (pp_bus),
    .neg       (neg),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  b;
    logic [51:0] pp;   // {pp3, pp2, pp1, pp0}
    logic [3:0]  neg;
    int          prod;
  } vec_t;

  vec_t vecs[9];
  int   checks    = 0;
  int   errors    = 0;
  int   accepted  = 0;
  int   delivered = 0;
  int   exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Sum of (signed pp_i + neg_i) * 4^i, truncated to the product width.
  function automatic logic [19:0] recon(input logic [51:0] bus, input logic [3:0] n);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [12:0] p;
      p = bus[i*13 +: 13];
      s += (int'(p) + int'(n[i])) * (1 << (2*i));
    end
    return s[19:0];
  endfunction

  // One clock: drive at posedge+1, observe handshakes at negedge, return at next posedge+1.
  task automatic cycle(input logic iv, input logic [11:0] a, input logic [7:0] b, input logic ordy);
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    out_ready = ordy;
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(int'($signed(a_in)) * int'($signed(b_in)));
      accepted++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out_valid=1 with pp_bus=%0h, required no delivery", pp_bus);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_product", 64'(recon(pp_bus, neg)), 64'(e[19:0]));
        delivered++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int a0;
    int cyc;

    vecs[0] = '{12'h005, 8'h03, {13'h0000, 13'h0000, 13'h0005, 13'h1FFA}, 4'b0001, 15};
    vecs[1] = '{12'h800, 8'h80, {13'h0FFF, 13'h0000, 13'h0000, 13'h0000}, 4'b1000, 262144};
    vecs[2] = '{12'h7FF, 8'h7F, {13'h0FFE, 13'h0000, 13'h0000, 13'h1800}, 4'b0001, 259969};
    vecs[3] = '{12'h000, 8'h00, {13'h0000, 13'h0000, 13'h0000, 13'h0000}, 4'b0000, 0};
    vecs[4] = '{12'h001, 8'hFF, {13'h0000, 13'h0000, 13'h0000, 13'h1FFE}, 4'b0001, -1};
    vecs[5] = '{12'hFFF, 8'h02, {13'h0000, 13'h0000, 13'h1FFF, 13'h0001}, 4'b0001, -2};
    vecs[6] = '{12'h800, 8'h01, {13'h0000, 13'h0000, 13'h0000, 13'h1800}, 4'b0000, -2048};
    vecs[7] = '{12'h123, 8'h55, {13'h0123, 13'h0123, 13'h0123, 13'h0123}, 4'b0000, 24735};
    vecs[8] = '{12'h123, 8'hAA, {13'h1EDC, 13'h1EDC, 13'h1EDC, 13'h1DB9}, 4'b1111, -25026};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_pp_bus",    64'(pp_bus),    64'(0));
    chk("rst_neg",       64'(neg),       64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, one set in flight at a time; output valid after the second edge.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      chk($sformatf("v%0d_latency_early", i), 64'(out_valid), 64'(0));
      cycle(1'b0, 12'h000, 8'h00, 1'b1);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("v%0d_pp_bus", i),    64'(pp_bus),    64'(vecs[i].pp));
      chk($sformatf("v%0d_neg", i),       64'(neg),       64'(vecs[i].neg));
      chk($sformatf("v%0d_product", i),   64'(recon(pp_bus, neg)), 64'(vecs[i].prod[19:0]));
    end
    cycle(1'b0, 12'h000, 8'h00, 1'b1);
    chk("idle_busy", 64'(busy), 64'(0));

    // Back-to-back three sets with a four-cycle stall on the first delivery.
    d0 = delivered;
    cycle(1'b1, 12'h005, 8'h03, 1'b0);
    cycle(1'b1, 12'h800, 8'h80, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_in_ready", k),  64'(in_ready),  64'(0));
      chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'(1));
      chk($sformatf("stall%0d_pp_bus", k),    64'(pp_bus),    64'(vecs[0].pp));
      chk($sformatf("stall%0d_neg", k),       64'(neg),       64'(4'b0001));
      chk($sformatf("stall%0d_busy", k),      64'(busy),      64'(1));
      cycle(1'b1, 12'h7FF, 8'h7F, 1'b0);
    end
    cycle(1'b1, 12'h7FF, 8'h7F, 1'b1);
    repeat (3) cycle(1'b0, 12'h000, 8'h00, 1'b1);
    chk("stall_delivered", 64'(delivered - d0), 64'(3));
    chk("stall_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("stall_busy_end", 64'(busy), 64'(0));

    // Reset with two sets in flight: everything is discarded immediately.
    cycle(1'b1, 12'h123, 8'h55, 1'b1);
    cycle(1'b1, 12'h123, 8'hAA, 1'b1);
    chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy",      64'(busy),      64'(0));
    chk("midrst_in_ready",  64'(in_ready),  64'(1));
    chk("midrst_pp_bus",    64'(pp_bus),    64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 12'h000, 8'h00, 1'b1);
      chk($sformatf("postrst%0d_out_valid", k), 64'(out_valid), 64'(0));
    end
    d0 = delivered;
    cycle(1'b1, 12'h005, 8'h03, 1'b1);
    cycle(1'b0, 12'h000, 8'h00, 1'b1);
    chk("postrst_pp_bus", 64'(pp_bus), 64'(vecs[0].pp));
    cycle(1'b0, 12'h000, 8'h00, 1'b1);
    chk("postrst_delivered", 64'(delivered - d0), 64'(1));

    // Random operands with random back-pressure; scoreboard checks product and order.
    a0  = accepted;
    d0  = delivered;
    cyc = 0;
    while ((accepted - a0) < 10000 && cyc < 60000) begin
      cycle(($urandom_range(0, 3) != 0), 12'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_accept_budget", 64'(accepted - a0), 64'(10000));
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      cycle(1'b0, 12'h000, 8'h00, 1'b1);
    end
    chk("rand_delivered", 64'(delivered - d0), 64'(accepted - a0));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
